// File: rtl/acc_pkg.sv
// Shared types and helpers for the matrix-multiply compute core.
package acc_pkg;

  localparam int DIM_DEF    = 32;
  localparam int DATA_W_DEF = 8;

  // Accumulator wide enough for DIM products of two DATA_W-bit values.
  function automatic int acc_width(input int dim, input int data_w);
    return 2 * data_w + $clog2(dim);
  endfunction

  function automatic int row_major(input int row, input int col, input int dim);
    return row * dim + col;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    WRITE
  } acc_state_t;

endpackage

// File: rtl/acc_matmul_core_if.sv
// Front-end <-> compute core connection: start level, operand matrices, result and status.
interface acc_matmul_core_if
  import acc_pkg::*;
#(
  parameter int DIM    = DIM_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic                               start;
  logic [DIM*DIM-1:0][DATA_W-1:0]     acc_in_A;
  logic [DIM*DIM-1:0][DATA_W-1:0]     acc_in_B;
  logic [DIM*DIM-1:0][DATA_W-1:0]     acc_out;
  logic                               done;
  logic                               busy;

  modport master (
    output start, acc_in_A, acc_in_B,
    input  acc_out, done, busy
  );

  modport slave (
    input  start, acc_in_A, acc_in_B,
    output acc_out, done, busy
  );

endinterface

// File: rtl/acc_matmul_core_mac.sv
// Multiply-accumulate unit with clipped byte output.
// ACC_SAT_EN defined: saturate to 2^DATA_W-1; undefined: keep the low DATA_W bits.
module acc_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] clip_out
);

  logic [ACC_W-1:0]    acc_reg;
  logic [2*DATA_W-1:0] prod;

  assign prod = a * b;

  // Clear wins over enable so a new element always starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_reg + ACC_W'(prod);
    end
  end

`ifdef ACC_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'({DATA_W{1'b1}});

  assign clip_out = (acc_reg > SAT_MAX) ? {DATA_W{1'b1}} : acc_reg[DATA_W-1:0];
`else
  logic unused_acc_hi;

  assign unused_acc_hi = ^acc_reg[ACC_W-1:DATA_W];
  assign clip_out      = acc_reg[DATA_W-1:0];
`endif

endmodule

// File: rtl/acc_matmul_core.sv
// Sequential C = A x B over DIM x DIM unsigned bytes, one MAC per cycle.
// Output clipping is selected by the ACC_SAT_EN macro (see acc_mac).
module acc_matmul_core
  import acc_pkg::*;
#(
  parameter int DIM    = DIM_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  acc_matmul_core_if.slave bus
);

  localparam int CNT_W = $clog2(DIM);
  localparam int IDX_W = 2 * CNT_W;
  localparam int ACC_W = acc_width(DIM, DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIM - 1);

  acc_state_t state_reg, state_next;
  logic [CNT_W-1:0] i_reg, i_next;
  logic [CNT_W-1:0] j_reg, j_next;
  logic [CNT_W-1:0] k_reg, k_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             start_q;
  logic             start_edge;
  logic             mac_clr;
  logic             mac_en;
  logic             wr_en;
  logic [IDX_W-1:0] a_idx;
  logic [IDX_W-1:0] b_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [DATA_W-1:0] a_sel;
  logic [DATA_W-1:0] b_sel;
  logic [DATA_W-1:0] clip_val;

  assign start_edge = bus.start & ~start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      i_reg     <= '0;
      j_reg     <= '0;
      k_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      k_reg     <= k_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      start_q   <= bus.start;
    end
  end

  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    k_next     = k_reg;
    busy_next  = busy_reg;
    done_next  = done_reg;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    wr_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        // Edges arriving in MAC/WRITE never reach here, so they are ignored.
        if (start_edge) begin
          i_next     = '0;
          j_next     = '0;
          k_next     = '0;
          mac_clr    = 1'b1;
          done_next  = 1'b0;
          busy_next  = 1'b1;
          state_next = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (k_reg == LAST) begin
          k_next     = '0;
          state_next = WRITE;
        end else begin
          k_next = k_reg + 1'b1;
        end
      end
      WRITE: begin
        wr_en   = 1'b1;
        mac_clr = 1'b1;
        k_next  = '0;
        if (j_reg == LAST) begin
          j_next = '0;
          i_next = i_reg + 1'b1;
        end else begin
          j_next = j_reg + 1'b1;
        end
        if ((i_reg == LAST) && (j_reg == LAST)) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          state_next = MAC;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operands are read live from the front-end; they must stay stable while busy.
  assign a_idx  = IDX_W'(row_major(int'(i_reg), int'(k_reg), DIM));
  assign b_idx  = IDX_W'(row_major(int'(k_reg), int'(j_reg), DIM));
  assign wr_idx = IDX_W'(row_major(int'(i_reg), int'(j_reg), DIM));
  assign a_sel  = bus.acc_in_A[a_idx];
  assign b_sel  = bus.acc_in_B[b_idx];

  acc_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clr      (mac_clr),
    .en       (mac_en),
    .a        (a_sel),
    .b        (b_sel),
    .clip_out (clip_val)
  );

  genvar gi;
  generate
    for (gi = 0; gi < DIM * DIM; gi++) begin : g_out
      logic [DATA_W-1:0] elem_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          elem_reg <= '0;
        end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
          elem_reg <= clip_val;
        end
      end

      assign bus.acc_out[gi] = elem_reg;
    end
  endgenerate

  assign bus.done = done_reg;
  assign bus.busy = busy_reg;

endmodule

// File: tb/tb_acc_matmul_core.sv
// Directed bench for acc_matmul_core at DIM=4: result vectors, latency, retrigger and reset cases.
module tb_acc_matmul_core;

  localparam int DIM = 4;
  localparam int DW  = 8;
  localparam int N   = DIM * DIM;
  localparam int NV  = 5;

  typedef struct {
    logic [N-1:0][DW-1:0] a;
    logic [N-1:0][DW-1:0] b;
    logic [N-1:0][DW-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  vec_t vecs [NV];
  int   total = 0;
  int   bad   = 0;
  int   lat;
  int   bcyc;

  always #5 clk = ~clk;

  acc_matmul_core_if #(.DIM(DIM), .DATA_W(DW)) bus ();

  acc_matmul_core #(.DIM(DIM), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic load(input int vi);
    @(negedge clk);
    bus.acc_in_A = vecs[vi].a;
    bus.acc_in_B = vecs[vi].b;
  endtask

  // Leaves start high at a negedge; the following posedge accepts the edge.
  task automatic launch();
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
  endtask

  // Cycle 1 is the accepting clock. A pulse low at toggle_at tests mid-run retrigger.
  task automatic wait_done(input int toggle_at, output int lat_o, output int bcyc_o);
    lat_o  = 0;
    bcyc_o = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (bus.busy) bcyc_o++;
      if (bus.busy && bus.done) check("done_busy_overlap", 1, 0);
      if (c == 1) begin
        check("accept_done_clear", int'(bus.done), 0);
        check("accept_busy_set", int'(bus.busy), 1);
      end
      if (c == toggle_at) bus.start = 1'b0;
      if (c == toggle_at + 1) bus.start = 1'b1;
      if (bus.done) begin
        lat_o = c;
        break;
      end
    end
    if (lat_o == 0) check("done_timeout", 0, 1);
  endtask

  task automatic check_result(input int vi, input string tag);
    for (int n = 0; n < N; n++) begin
      check($sformatf("%s v%0d c[%0d]", tag, vi, n), int'(bus.acc_out[n]), int'(vecs[vi].exp[n]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < N; n++) begin
      automatic int r = n / DIM;
      automatic int c = n % DIM;
      vecs[0].a[n] = (r == c) ? 8'd1 : 8'd0;
      vecs[0].b[n] = 8'(n + 1);
      vecs[0].exp[n] = 8'(n + 1);
      vecs[1].a[n] = 8'd1;
      vecs[1].b[n] = 8'd1;
      vecs[1].exp[n] = 8'd4;
      vecs[2].a[n] = 8'd255;
      vecs[2].b[n] = 8'd255;
`ifdef ACC_SAT_EN
      vecs[2].exp[n] = 8'd255;
`else
      vecs[2].exp[n] = 8'd4;
`endif
      vecs[3].a[n] = 8'(r + c);
      vecs[3].b[n] = 8'd1;
      vecs[3].exp[n] = 8'(4 * r + 6);
      vecs[4].a[n] = 8'd1;
      vecs[4].b[n] = 8'(4 * r + c);
      vecs[4].exp[n] = 8'(24 + 4 * c);
    end

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.acc_in_A = '0;
    bus.acc_in_B = '0;
    repeat (2) @(negedge clk);
    check("reset_done", int'(bus.done), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_acc_out_any", int'(|bus.acc_out), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", int'(bus.busy), 0);

    for (int vi = 0; vi < NV; vi++) begin
      load(vi);
      launch();
      wait_done(-10, lat, bcyc);
      check($sformatf("v%0d latency", vi), lat, 81);
      check($sformatf("v%0d busy_cycles", vi), bcyc, 80);
      check_result(vi, "table");
      $display("vec %0d: latency=%0d busy_cycles=%0d c[0]=%0d c[15]=%0d",
               vi, lat, bcyc, bus.acc_out[0], bus.acc_out[N-1]);
    end

    // start stays high after completion: no second run.
    repeat (20) @(posedge clk);
    #1;
    check("hold_done", int'(bus.done), 1);
    check("hold_busy", int'(bus.busy), 0);
    $display("hold: done=%0d busy=%0d", bus.done, bus.busy);

    load(3);
    launch();
    wait_done(10, lat, bcyc);
    check("toggle latency", lat, 81);
    check_result(3, "toggle");
    $display("toggle: latency=%0d busy_cycles=%0d", lat, bcyc);

    load(0);
    launch();
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_acc_out_any", int'(|bus.acc_out), 0);
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b0;
    launch();
    wait_done(-10, lat, bcyc);
    check("after_rst latency", lat, 81);
    check_result(0, "after_rst");
    $display("reset_mid_run: latency=%0d busy_cycles=%0d", lat, bcyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
